// File: rtl/mem_req_arbiter_pkg.sv
// mem_req_arbiter_pkg
//   Shared constants and types for the two-port memory request arbiter.
//   - Memory line geometry (data width, beats per line, address width).
//   - Tag widths. The memory tag is the dcache tag plus one source bit.
//   - FSM state encoding, source ids, and the request bundle used for muxing.
//   Optional feature macro used by the arbiter: MEM_ARB_ROUND_ROBIN_EN.
package mem_req_arbiter_pkg;

    function automatic int ceil_log2(input int n);
        int r;
        r = 0;
        while ((1 << r) < n) r = r + 1;
        return r;
    endfunction

    localparam int MEM_DATA_BITS   = 128;
    localparam int MEM_DATA_CYCLES = 4;   // power of two, >= 2
    localparam int WORD_ADDR_BITS  = 30;
    localparam int MEM_REQ_LSB     = ceil_log2(MEM_DATA_BITS / 64);
    localparam int ADDR_W          = WORD_ADDR_BITS - MEM_REQ_LSB;
    localparam int DC_TAG_BITS     = 4;
    localparam int TAG_W           = DC_TAG_BITS + 1;
    localparam int WCNT_W          = ceil_log2(MEM_DATA_CYCLES);

    // Source id carried in the top bit of the memory tag
    localparam logic SRC_IP = 1'b0;
    localparam logic SRC_DC = 1'b1;

    typedef enum logic {
        S_IDLE  = 1'b0,
        S_WDATA = 1'b1
    } arb_state_t;

    typedef struct packed {
        logic              rw;
        logic [ADDR_W-1:0] addr;
        logic [TAG_W-1:0]  tag;
    } mem_req_t;

endpackage

// File: rtl/mem_req_arbiter_if.sv
// mem_req_arbiter_if
//   Bundles every handshake/data signal around the arbiter:
//   - ip_req_*  : prefetcher request (val/rdy, addr, 1-bit tag)
//   - dc_req_*  : dcache request (val/rdy, rw, addr, tag) and write-data beats
//   - ip_resp_* / dc_resp_* : responses and nacks steered back by tag
//   - mem_req_* / mem_resp_* : the single downstream memory port
//   Modports:
//   - master : the arbiter (owns the memory port, answers the clients)
//   - slave  : the environment (clients plus memory)
interface mem_req_arbiter_if;
    import mem_req_arbiter_pkg::*;

    logic                     ip_req_val;
    logic                     ip_req_rdy;
    logic [ADDR_W-1:0]        ip_req_addr;
    logic                     ip_req_tag;

    logic                     dc_req_val;
    logic                     dc_req_rdy;
    logic                     dc_req_rw;
    logic [ADDR_W-1:0]        dc_req_addr;
    logic [DC_TAG_BITS-1:0]   dc_req_tag;
    logic                     dc_req_data_val;
    logic                     dc_req_data_rdy;
    logic [MEM_DATA_BITS-1:0] dc_req_data_bits;

    logic                     ip_resp_val;
    logic                     ip_resp_nack;
    logic                     ip_resp_tag;
    logic [MEM_DATA_BITS-1:0] ip_resp_data;
    logic                     dc_resp_val;
    logic                     dc_resp_nack;
    logic [DC_TAG_BITS-1:0]   dc_resp_tag;
    logic [MEM_DATA_BITS-1:0] dc_resp_data;

    logic                     mem_req_val;
    logic                     mem_req_rdy;
    logic                     mem_req_rw;
    logic [ADDR_W-1:0]        mem_req_addr;
    logic [TAG_W-1:0]         mem_req_tag;
    logic                     mem_req_data_val;
    logic                     mem_req_data_rdy;
    logic [MEM_DATA_BITS-1:0] mem_req_data_bits;
    logic                     mem_resp_val;
    logic                     mem_resp_nack;
    logic [MEM_DATA_BITS-1:0] mem_resp_data;
    logic [TAG_W-1:0]         mem_resp_tag;

    modport master (
        input  ip_req_val, ip_req_addr, ip_req_tag,
        output ip_req_rdy,
        input  dc_req_val, dc_req_rw, dc_req_addr, dc_req_tag,
        output dc_req_rdy,
        input  dc_req_data_val, dc_req_data_bits,
        output dc_req_data_rdy,
        output ip_resp_val, ip_resp_nack, ip_resp_tag, ip_resp_data,
        output dc_resp_val, dc_resp_nack, dc_resp_tag, dc_resp_data,
        output mem_req_val, mem_req_rw, mem_req_addr, mem_req_tag,
        input  mem_req_rdy,
        output mem_req_data_val, mem_req_data_bits,
        input  mem_req_data_rdy,
        input  mem_resp_val, mem_resp_nack, mem_resp_data, mem_resp_tag
    );

    modport slave (
        output ip_req_val, ip_req_addr, ip_req_tag,
        input  ip_req_rdy,
        output dc_req_val, dc_req_rw, dc_req_addr, dc_req_tag,
        input  dc_req_rdy,
        output dc_req_data_val, dc_req_data_bits,
        input  dc_req_data_rdy,
        input  ip_resp_val, ip_resp_nack, ip_resp_tag, ip_resp_data,
        input  dc_resp_val, dc_resp_nack, dc_resp_tag, dc_resp_data,
        input  mem_req_val, mem_req_rw, mem_req_addr, mem_req_tag,
        output mem_req_rdy,
        input  mem_req_data_val, mem_req_data_bits,
        output mem_req_data_rdy,
        output mem_resp_val, mem_resp_nack, mem_resp_data, mem_resp_tag
    );

endinterface

// File: rtl/mem_req_arbiter_prio.sv
// mem_arb_prio
//   Two-input grant picker for the arbiter.
//   Ports:
//   - ip_val, dc_val : requests from the I-side and D-side
//   - gnt_dc         : 1 = D-side wins this cycle, 0 = I-side
//   With MEM_ARB_ROUND_ROBIN_EN defined, a last_grant flop (clk, reset, fire
//   ports) makes a tie go to the side not granted last; otherwise the D-side
//   always wins a tie and no state exists.
module mem_arb_prio
    import mem_req_arbiter_pkg::*;
(
`ifdef MEM_ARB_ROUND_ROBIN_EN
    input  logic clk,
    input  logic reset,
    input  logic fire,     // a memory request handshake completed this cycle
`endif
    input  logic ip_val,
    input  logic dc_val,
    output logic gnt_dc
);

    logic prio_dc;

`ifdef MEM_ARB_ROUND_ROBIN_EN
    logic last_grant;

    always_ff @(posedge clk or posedge reset) begin
        if (reset)
            last_grant <= SRC_IP;
        else if (fire)
            last_grant <= gnt_dc ? SRC_DC : SRC_IP;
    end

    assign prio_dc = (last_grant == SRC_IP);
`else
    assign prio_dc = 1'b1;
`endif

    assign gnt_dc = dc_val & (~ip_val | prio_dc);

endmodule

// File: rtl/mem_req_arbiter.sv
// mem_req_arbiter
//   Merges prefetcher (I-side) and dcache (D-side) requests onto one memory
//   port. The memory tag gets a source bit on top so responses and nacks can
//   be steered back combinationally. A D-side writeback holds the port for
//   MEM_DATA_CYCLES write-data beats (WDATA state) before arbitration resumes.
//   Ports:
//   - clk, reset : clock, asynchronous active-high reset
//   - bus        : mem_req_arbiter_if.master (client requests, write beats,
//                  responses, memory request/response port)
//   Build option: MEM_ARB_ROUND_ROBIN_EN selects round-robin tie breaking
//   instead of fixed D-side priority.
module mem_req_arbiter
    import mem_req_arbiter_pkg::*;
(
    input  logic              clk,
    input  logic              reset,
    mem_req_arbiter_if.master bus
);

    arb_state_t        state, state_nxt;
    logic [WCNT_W-1:0] wcnt, wcnt_nxt;
    logic              gnt_dc;
    logic              dc_wr_fire;
    logic              beat_fire;
    mem_req_t          ip_req, dc_req, sel_req;

    mem_arb_prio u_prio (
`ifdef MEM_ARB_ROUND_ROBIN_EN
        .clk    (clk),
        .reset  (reset),
        .fire   (bus.mem_req_val & bus.mem_req_rdy),
`endif
        .ip_val (bus.ip_req_val),
        .dc_val (bus.dc_req_val),
        .gnt_dc (gnt_dc)
    );

    // I-side never writes; its one tag bit sits at the bottom of the field
    assign ip_req = '{rw:   1'b0,
                      addr: bus.ip_req_addr,
                      tag:  {SRC_IP, {(DC_TAG_BITS-1){1'b0}}, bus.ip_req_tag}};
    assign dc_req = '{rw:   bus.dc_req_rw,
                      addr: bus.dc_req_addr,
                      tag:  {SRC_DC, bus.dc_req_tag}};
    assign sel_req = gnt_dc ? dc_req : ip_req;

    assign dc_wr_fire = bus.dc_req_val & gnt_dc & bus.mem_req_rdy & bus.dc_req_rw;
    assign beat_fire  = bus.dc_req_data_val & bus.mem_req_data_rdy;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state <= S_IDLE;
            wcnt  <= '0;
        end else begin
            state <= state_nxt;
            wcnt  <= wcnt_nxt;
        end
    end

    always_comb begin
        state_nxt             = state;
        wcnt_nxt              = wcnt;

        bus.mem_req_val       = 1'b0;
        bus.ip_req_rdy        = 1'b0;
        bus.dc_req_rdy        = 1'b0;
        bus.mem_req_data_val  = 1'b0;
        bus.dc_req_data_rdy   = 1'b0;
        bus.ip_resp_val       = 1'b0;
        bus.ip_resp_nack      = 1'b0;
        bus.dc_resp_val       = 1'b0;
        bus.dc_resp_nack      = 1'b0;

        // Data and tag fields are don't-care without a valid, so they pass
        // through unconditionally.
        bus.mem_req_rw        = sel_req.rw;
        bus.mem_req_addr      = sel_req.addr;
        bus.mem_req_tag       = sel_req.tag;
        bus.mem_req_data_bits = bus.dc_req_data_bits;
        bus.ip_resp_tag       = bus.mem_resp_tag[0];
        bus.dc_resp_tag       = bus.mem_resp_tag[DC_TAG_BITS-1:0];
        bus.ip_resp_data      = bus.mem_resp_data;
        bus.dc_resp_data      = bus.mem_resp_data;

        // Every handshake output is forced low while reset is asserted
        if (!reset) begin
            // Responses are steered by the source bit in any state; nacks
            // follow the same bit even without mem_resp_val.
            bus.ip_resp_val  = bus.mem_resp_val  & (bus.mem_resp_tag[TAG_W-1] == SRC_IP);
            bus.dc_resp_val  = bus.mem_resp_val  & (bus.mem_resp_tag[TAG_W-1] == SRC_DC);
            bus.ip_resp_nack = bus.mem_resp_nack & (bus.mem_resp_tag[TAG_W-1] == SRC_IP);
            bus.dc_resp_nack = bus.mem_resp_nack & (bus.mem_resp_tag[TAG_W-1] == SRC_DC);

            case (state)
                S_IDLE: begin
                    bus.mem_req_val = gnt_dc ? bus.dc_req_val : bus.ip_req_val;
                    bus.ip_req_rdy  = bus.mem_req_rdy & ~gnt_dc;
                    bus.dc_req_rdy  = bus.mem_req_rdy &  gnt_dc;
                    if (dc_wr_fire) begin
                        state_nxt = S_WDATA;
                        wcnt_nxt  = '0;
                    end
                end
                S_WDATA: begin
                    bus.mem_req_data_val = bus.dc_req_data_val;
                    bus.dc_req_data_rdy  = bus.mem_req_data_rdy;
                    if (beat_fire) begin
                        if (wcnt == WCNT_W'(MEM_DATA_CYCLES - 1)) begin
                            wcnt_nxt  = '0;
                            state_nxt = S_IDLE;
                        end else begin
                            wcnt_nxt  = wcnt + 1'b1;
                        end
                    end
                end
                default: state_nxt = S_IDLE;
            endcase
        end
    end

endmodule
